stream_demux_1xn: RTL and testbench
===================================

Name: stream_demux_1xn

Overview:
Parametrised 1-to-N packet-stream demultiplexer with valid/ready handshake on every port. It routes each input packet to the output selected on the packet's first beat and locks that route until the last beat. Each output has a one-entry registered slot, giving one cycle of latency. Packets addressed to a nonexistent output are drained and counted. It replaces the fixed 4-way gate-level demux wherever data must be steered between back-pressured consumers.

Parameters:
N_OUT, 4, number of output channels (2..16)
DATA_W, 8, payload width in bits
SEL_W, 3, select width; 2**SEL_W >= N_OUT required (elaboration-time check)
CNT_W, 8, drop-counter width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_data  input  DATA_W  input payload
in_sel  input  SEL_W  destination; sampled only on the first beat of a packet
in_last  input  1  marks the final beat of a packet
out_valid  output  N_OUT  per-channel slot valid
out_ready  input  N_OUT  per-channel consumer ready
out_data  output  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
out_last  output  N_OUT  per-channel last flag
drop_cnt  output  CNT_W  dropped-packet count, saturating
busy  output  1  high while a packet is in progress (state PKT)

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0, drop_cnt=0, busy=0, state=IDLE, locked dest=0.
  - A packet in flight at reset is discarded; no partial output survives.
- FSM state IDLE:
  - Effective destination is in_sel.
  - An accepted beat with in_last=0 latches in_sel into the locked destination and moves to PKT.
  - An accepted beat with in_last=1 is a single-beat packet; stay in IDLE.
- FSM state PKT:
  - Effective destination is the locked destination; in_sel is ignored.
  - An accepted beat with in_last=1 returns to IDLE.
- Valid destination (dest < N_OUT):
  - in_ready = !out_valid[dest] || out_ready[dest]. This is combinational from out_ready; the path is documented as such.
  - On accept, slot[dest] loads in_data/in_last and out_valid[dest]=1 on the next edge (latency 1).
- Invalid destination (dest >= N_OUT):
  - in_ready=1; beats are consumed and discarded.
  - drop_cnt increments once per dropped packet, on its last beat, and saturates at 2**CNT_W-1.
- Output slot k:
  - Clears out_valid[k] when out_ready[k] && out_valid[k] and no new load occurs that cycle.
  - Simultaneous drain and load keeps out_valid[k]=1 with the new data, giving full throughput of 1 beat/cycle per channel.
  - out_data[k] and out_last[k] hold stable while out_valid[k] && !out_ready[k].
- Back-pressure on one channel never stalls the other channels' draining slots. Input stalls only when the current destination's slot is blocked.
- in_valid may drop mid-packet (bubbles allowed); the lock persists across bubbles.

Decomposition:
- Package stream_demux_pkg holds:
  - the state enum typedef (IDLE, PKT)
  - an elaboration-time sel_ok check function
  - the N_OUT/SEL_W sanity localparams
- Sub-module stream_demux_slot is a one-entry valid/ready register (DATA_W+1 bits), instantiated N_OUT times in a generate loop.
- The top level holds the FSM, route lock, drop logic and in_ready mux.

Test Plan:
- Reset then single beats: sel=2, data=0xA5, last=1 with all out_ready=1 -> out_valid=4'b0100 and out_data[2]=0xA5 one cycle later; other channels stay 0.
- 3-beat packet 0x11, 0x22, 0x33 with sel=1 on beat 1 and sel=3 on beats 2-3 -> all three beats appear on channel 1 in order; busy=1 from after beat 1 until after beat 3.
- Back-pressure: out_ready[0]=0 with two beats to channel 0 -> first beat is held stable, in_ready=0 on the second beat; releasing out_ready[0] delivers both beats, one per cycle.
- Streaming throughput: out_ready[3]=1, 8 consecutive beats to channel 3 -> in_ready stays 1 and out_valid[3] stays high for 8 consecutive cycles.
- Drop: sel=6 (N_OUT=4) with a 2-beat packet -> in_ready=1, no out_valid asserted, drop_cnt goes 0 -> 1 on the last beat. Repeat with CNT_W=2 for 5 packets -> drop_cnt saturates at 3.
- rst_n asserted mid-packet to channel 2 with the slot full -> out_valid=0 and busy=0 immediately. After release, a new packet with sel=0 routes to channel 0.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and configuration checks for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

  localparam int MIN_OUT = 2;
  localparam int MAX_OUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  // Legal only if the channel count is in range and every channel is addressable.
  function automatic bit sel_ok(input int n_out, input int sel_w);
    return (n_out >= MIN_OUT) && (n_out <= MAX_OUT) && ((1 << sel_w) >= n_out);
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry valid/ready register holding a payload beat and its last flag.
module stream_demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  // A load in the same cycle as a drain wins, keeping valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1xn.sv
// 1-to-N packet demux: route chosen on the first beat and held until the last;
// packets addressed past N_OUT are swallowed and counted.
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_last,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_last,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    busy
);

  if (!sel_ok(N_OUT, SEL_W)) begin : g_bad_cfg
    $error("stream_demux_1xn: N_OUT must be 2..16 and fit in SEL_W bits");
  end

  localparam logic [SEL_W:0] N_OUT_V = (SEL_W+1)'(N_OUT);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] dest_q;
  logic [SEL_W-1:0] dest;
  logic             dest_ok;
  logic             accept;
  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] load;

  assign dest    = (state_q == PKT) ? dest_q : in_sel;
  assign dest_ok = {1'b0, dest} < N_OUT_V;

  // in_ready is combinational from out_ready of the selected channel.
  assign in_ready = !dest_ok || |(hit & (~out_valid | out_ready));
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == PKT);

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    assign hit[k]  = dest_ok && (dest == SEL_W'(k));
    assign load[k] = accept && hit[k];

    stream_demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .load_last (in_last),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*DATA_W +: DATA_W]),
      .last      (out_last[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !in_last) state_d = PKT;
      PKT:  if (accept &&  in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                dest_q <= '0;
    else if (state_q == IDLE && accept && !in_last) dest_q <= in_sel;
  end

  // One count per discarded packet, taken on its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (accept && !dest_ok && in_last && drop_cnt != '1)
      drop_cnt <= drop_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Randomized and directed checks of stream_demux_1xn against a beat-level model.
module tb_stream_demux_1xn;
  localparam int N_OUT  = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data = '0;
  logic [SEL_W-1:0]        in_sel = '0;
  logic                    in_last = 1'b0;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready = '0;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_last;
  logic [CNT_W-1:0]        drop_cnt;
  logic                    busy;

  stream_demux_1xn #(.N_OUT(N_OUT), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: what each channel currently holds, packet lock, drop tally.
  bit              mv[N_OUT];
  logic [DATA_W-1:0] md[N_OUT];
  bit              ml[N_OUT];
  bit              in_pkt;
  int              ldest;
  int              drops;
  logic            seen_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_OUT; k++) begin
      mv[k] = 0; md[k] = '0; ml[k] = 0;
    end
    in_pkt = 0; ldest = 0; drops = 0;
  endtask

  task automatic compare_outputs();
    for (int k = 0; k < N_OUT; k++) begin
      chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(mv[k]));
      chk($sformatf("out_data[%0d]", k), 64'(out_data[k*DATA_W +: DATA_W]), 64'(md[k]));
      chk($sformatf("out_last[%0d]", k), 64'(out_last[k]), 64'(ml[k]));
    end
    chk("drop_cnt", 64'(drop_cnt), 64'(drops));
    chk("busy", 64'(busy), 64'(in_pkt));
  endtask

  // One clock: apply inputs, check in_ready, advance model, check outputs.
  task automatic step(input bit v, input int s, input logic [DATA_W-1:0] d,
                      input bit l, input logic [N_OUT-1:0] r);
    int dest;
    bit ok, er, acc;
    @(negedge clk);
    in_valid = v; in_sel = SEL_W'(s); in_data = d; in_last = l; out_ready = r;
    #1;
    dest = in_pkt ? ldest : s;
    ok   = dest < N_OUT;
    er   = !ok || !mv[dest] || r[dest];
    seen_rdy = in_ready;
    chk("in_ready", 64'(in_ready), 64'(er));
    acc = v && er;
    @(posedge clk);
    #1;
    for (int k = 0; k < N_OUT; k++) begin
      if (acc && ok && dest == k) begin
        mv[k] = 1; md[k] = d; ml[k] = l;
      end else if (r[k]) begin
        mv[k] = 0;
      end
    end
    if (acc && !ok && l && drops < CMAX) drops++;
    if (acc) begin
      if (!in_pkt && !l) begin in_pkt = 1; ldest = s; end
      else if (in_pkt && l) in_pkt = 0;
    end
    compare_outputs();
  endtask

  initial begin
    int cnt;
    model_reset();
    #12;
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset out_data", 64'(out_data), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset drop_cnt", 64'(drop_cnt), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // Single beat to channel 2.
    step(1, 2, 8'hA5, 1, 4'hF);
    chk("single out_valid", 64'(out_valid), 64'(4'b0100));
    chk("single out_data2", 64'(out_data[23:16]), 64'(8'hA5));

    // Three-beat packet; in_sel changes after beat 1 must be ignored.
    step(1, 1, 8'h11, 0, 4'hF);
    chk("pkt busy after beat1", 64'(busy), 64'(1));
    chk("pkt beat1 ch1", 64'(out_data[15:8]), 64'(8'h11));
    step(1, 3, 8'h22, 0, 4'hF);
    chk("pkt beat2 ch1", 64'(out_data[15:8]), 64'(8'h22));
    chk("pkt ch3 idle", 64'(out_valid[3]), 64'(0));
    step(1, 3, 8'h33, 1, 4'hF);
    chk("pkt beat3 ch1", 64'(out_data[15:8]), 64'(8'h33));
    chk("pkt busy after beat3", 64'(busy), 64'(0));

    // Back-pressure on channel 0.
    step(1, 0, 8'h44, 1, 4'hE);
    step(1, 0, 8'h55, 1, 4'hE);
    chk("bp in_ready low", 64'(seen_rdy), 64'(0));
    chk("bp hold data", 64'(out_data[7:0]), 64'(8'h44));
    step(1, 0, 8'h55, 1, 4'hF);
    chk("bp release in_ready", 64'(seen_rdy), 64'(1));
    chk("bp second beat", 64'(out_data[7:0]), 64'(8'h55));
    step(0, 0, 8'h00, 0, 4'hF);
    chk("bp drained", 64'(out_valid[0]), 64'(0));

    // Streaming eight beats to channel 3.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 3, 8'(8'h60 + i), (i == 7), 4'hF);
      if (seen_rdy && out_valid[3]) cnt++;
    end
    chk("stream 8 cycles", 64'(cnt), 64'(8));

    // Two-beat packet to a nonexistent output.
    step(1, 6, 8'hD0, 0, 4'hF);
    chk("drop mid drop_cnt", 64'(drop_cnt), 64'(0));
    step(1, 2, 8'hD1, 1, 4'hF);
    chk("drop out_valid", 64'(out_valid), 64'(0));
    chk("drop count 1", 64'(drop_cnt), 64'(1));

    // Random traffic including bubbles, back-pressure and drops.
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 7), 8'($urandom),
           ($urandom_range(0, 2) == 0), N_OUT'($urandom));

    // Saturation of the drop counter.
    for (int i = 0; i < CMAX + 5; i++) step(1, 7, 8'hEE, 1, 4'hF);
    chk("drop saturate", 64'(drop_cnt), 64'(CMAX));

    // Reset mid-packet with channel 2 holding a beat.
    step(1, 2, 8'hC1, 0, 4'h0);
    chk("pre-reset busy", 64'(busy), 64'(1));
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("async reset out_valid", 64'(out_valid), 64'(0));
    chk("async reset busy", 64'(busy), 64'(0));
    chk("async reset drop_cnt", 64'(drop_cnt), 64'(0));
    model_reset();
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step(1, 0, 8'h77, 1, 4'hF);
    chk("post-reset route", 64'(out_valid), 64'(4'b0001));
    chk("post-reset data", 64'(out_data[7:0]), 64'(8'h77));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
